// File: rtl/raifes_dm_cmd_ctrl_if.sv
// Command and ROM-status bundle of the abstract-command sequencer.
// slave = sequencer side; master = DMI register file plus ROM status side.
interface raifes_dm_cmd_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [4:0]  cmd_regno;
    logic        cmd_postexec;
    logic [31:0] dmi_progbuf0;
    logic [31:0] dmi_progbuf1;
    logic [31:0] progbuf0;
    logic [31:0] progbuf1;
    logic        postexec_req;
    logic        postexec_busy;
    logic        resume_req;
    logic        halted;
    logic        resume_ack;
    logic        busy;
    logic [2:0]  cmderr;
    logic        cmderr_clr;
    logic        data0_access;

    modport slave (
        input  cmd_valid, cmd_type, cmd_regno, cmd_postexec,
        input  dmi_progbuf0, dmi_progbuf1,
        input  postexec_busy, halted, resume_ack,
        input  cmderr_clr, data0_access,
        output cmd_ready, progbuf0, progbuf1,
        output postexec_req, resume_req, busy, cmderr
    );

    modport master (
        output cmd_valid, cmd_type, cmd_regno, cmd_postexec,
        output dmi_progbuf0, dmi_progbuf1,
        output postexec_busy, halted, resume_ack,
        output cmderr_clr, data0_access,
        input  cmd_ready, progbuf0, progbuf1,
        input  postexec_req, resume_req, busy, cmderr
    );
endinterface

// File: rtl/raifes_dm_cmd_ctrl.sv
// Abstract-command sequencer: builds progbuf0/1, drives postexec/resume handshakes to the debug ROM.
// Optional macro RAIFES_DM_AUTOEXEC_EN: data0_access re-issues the last register/exec command.
module raifes_dm_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] NOP_INSN       = 32'h00000013
) (
    input logic                 clk,
    input logic                 nreset,
    raifes_dm_cmd_ctrl_if.slave bus
);
    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   SW_BASE  = 32'h14002623;
    localparam logic [31:0]   LW_BASE  = 32'h14C02003;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ARM      = 3'd2,
        WAIT_SET = 3'd3,
        WAIT_CLR = 3'd4,
        RES_REQ  = 3'd5,
        RES_DROP = 3'd6
    } state_e;

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [1:0]    type_q;
    logic [4:0]    regno_q;
    logic          postexec_q;
    logic [31:0]   progbuf0_q;
    logic [31:0]   progbuf1_q;
    logic          postexec_req_q;
    logic          resume_req_q;
    logic          busy_q;
    logic [2:0]    cmderr_q;
    logic [2:0]    cmderr_d;
    logic [2:0]    err_set;
    logic          waiting;
    logic          progress;
    logic          timeout;
`ifdef RAIFES_DM_AUTOEXEC_EN
    logic          last_vld_q;
`else
    logic          unused_data0;
    assign unused_data0 = bus.data0_access;
`endif

    // Progress wins over an expiring timer in the same cycle.
    always_comb begin
        waiting  = 1'b0;
        progress = 1'b0;
        case (state_q)
            WAIT_SET: begin waiting = 1'b1; progress = bus.postexec_busy;  end
            WAIT_CLR: begin waiting = 1'b1; progress = !bus.postexec_busy; end
            RES_REQ:  begin waiting = 1'b1; progress = bus.resume_ack;     end
            RES_DROP: begin waiting = 1'b1; progress = !bus.halted;        end
            default: ;
        endcase
    end

    assign timeout = waiting && !progress && (timer_q == TMO_LAST);

    // cmderr is first-error-wins; a same-cycle clear beats any new error.
    always_comb begin
        err_set = 3'd0;
        if (state_q == IDLE) begin
            if (bus.cmd_valid && (bus.cmd_type != 2'd3) && !bus.halted)
                err_set = 3'd4;
        end else begin
            if (bus.cmd_valid)
                err_set = 3'd1;
`ifdef RAIFES_DM_AUTOEXEC_EN
            if (bus.data0_access)
                err_set = 3'd1;
`endif
            if (timeout)
                err_set = 3'd4;
        end
        if (bus.cmderr_clr)
            cmderr_d = 3'd0;
        else if (cmderr_q == 3'd0)
            cmderr_d = err_set;
        else
            cmderr_d = cmderr_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            type_q         <= 2'd0;
            regno_q        <= 5'd0;
            postexec_q     <= 1'b0;
            progbuf0_q     <= NOP_INSN;
            progbuf1_q     <= NOP_INSN;
            postexec_req_q <= 1'b0;
            resume_req_q   <= 1'b0;
            busy_q         <= 1'b0;
            cmderr_q       <= 3'd0;
`ifdef RAIFES_DM_AUTOEXEC_EN
            last_vld_q     <= 1'b0;
`endif
        end else begin
            cmderr_q       <= cmderr_d;
            timer_q        <= '0;
            postexec_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && (cmderr_q == 3'd0)) begin
                        if (bus.cmd_type == 2'd3) begin
                            if (bus.halted) begin
                                state_q      <= RES_REQ;
                                resume_req_q <= 1'b1;
                                busy_q       <= 1'b1;
                            end
                        end else if (bus.halted) begin
                            type_q     <= bus.cmd_type;
                            regno_q    <= bus.cmd_regno;
                            postexec_q <= bus.cmd_postexec;
                            state_q    <= LOAD;
                            busy_q     <= 1'b1;
`ifdef RAIFES_DM_AUTOEXEC_EN
                            last_vld_q <= 1'b1;
`endif
                        end
                    end
`ifdef RAIFES_DM_AUTOEXEC_EN
                    else if (bus.data0_access && (cmderr_q == 3'd0) && last_vld_q) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
`endif
                end
                LOAD: begin
                    case (type_q)
                        2'd0: begin
                            progbuf0_q <= SW_BASE | (32'(regno_q) << 20);
                            progbuf1_q <= postexec_q ? bus.dmi_progbuf0 : NOP_INSN;
                        end
                        2'd1: begin
                            progbuf0_q <= LW_BASE | (32'(regno_q) << 7);
                            progbuf1_q <= postexec_q ? bus.dmi_progbuf0 : NOP_INSN;
                        end
                        default: begin
                            progbuf0_q <= bus.dmi_progbuf0;
                            progbuf1_q <= bus.dmi_progbuf1;
                        end
                    endcase
                    state_q        <= ARM;
                    postexec_req_q <= 1'b1;
                end
                ARM: state_q <= WAIT_SET;
                WAIT_SET, WAIT_CLR, RES_REQ, RES_DROP: begin
                    if (progress) begin
                        case (state_q)
                            WAIT_SET: state_q <= WAIT_CLR;
                            RES_REQ: begin
                                state_q      <= RES_DROP;
                                resume_req_q <= 1'b0;
                            end
                            default: begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end else if (timeout) begin
                        // Abort keeps progbuf words; only the handshakes are dropped.
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        resume_req_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    resume_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = (state_q == IDLE);
    assign bus.progbuf0     = progbuf0_q;
    assign bus.progbuf1     = progbuf1_q;
    assign bus.postexec_req = postexec_req_q;
    assign bus.resume_req   = resume_req_q;
    assign bus.busy         = busy_q;
    assign bus.cmderr       = cmderr_q;
endmodule

// File: tb/tb_raifes_dm_cmd_ctrl.sv
// Scoreboard bench for raifes_dm_cmd_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_raifes_dm_cmd_ctrl;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    raifes_dm_cmd_ctrl_if bus ();

    raifes_dm_cmd_ctrl #(.TIMEOUT_CYCLES(16), .NOP_INSN(NOP)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] p0; logic [31:0] p1; } px_t;
    typedef struct { logic [2:0] val; int cyc; } ev_t;

    px_t q_px[$];
    ev_t q_err[$];
    ev_t q_done[$];
    int  q_res[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: postexec pulse -> progbuf words, cmderr change, busy fall, resume_req width
    logic       prev_px = 1'b0, prev_res = 1'b0, prev_busy = 1'b0;
    logic [2:0] prev_err = 3'd0;
    int         px_w = 0, res_w = 0, rw;
    px_t        ep;
    ev_t        ee;

    always @(negedge clk) begin
        if (!nreset) begin
            px_w  = 0;
            res_w = 0;
        end else begin
            if (bus.postexec_req) begin
                if (!prev_px) begin
                    chk("postexec_expected", 32'(q_px.size() != 0), 32'd1);
                    if (q_px.size() != 0) begin
                        ep = q_px.pop_front();
                        chk("progbuf0", bus.progbuf0, ep.p0);
                        chk("progbuf1", bus.progbuf1, ep.p1);
                    end
                end
                px_w++;
            end else if (prev_px) begin
                chk("postexec_width", px_w, 32'd1);
                px_w = 0;
            end
            if (bus.resume_req) begin
                res_w++;
            end else if (prev_res) begin
                chk("resume_expected", 32'(q_res.size() != 0), 32'd1);
                if (q_res.size() != 0) begin
                    rw = q_res.pop_front();
                    chk("resume_width", res_w, rw);
                end
                res_w = 0;
            end
            if (bus.cmderr != prev_err) begin
                chk("cmderr_change_expected", 32'(q_err.size() != 0), 32'd1);
                if (q_err.size() != 0) begin
                    ee = q_err.pop_front();
                    chk("cmderr_value", 32'(bus.cmderr), 32'(ee.val));
                    if (ee.cyc >= 0) chk("cmderr_cycle", cyc, ee.cyc);
                end
            end
            if (prev_busy && !bus.busy) begin
                chk("done_expected", 32'(q_done.size() != 0), 32'd1);
                if (q_done.size() != 0) begin
                    ee = q_done.pop_front();
                    chk("done_cmderr", 32'(bus.cmderr), 32'(ee.val));
                    if (ee.cyc >= 0) chk("done_cycle", cyc, ee.cyc);
                end
            end
        end
        prev_px   = bus.postexec_req;
        prev_res  = bus.resume_req;
        prev_busy = bus.busy;
        prev_err  = bus.cmderr;
    end

    task automatic issue(input logic [1:0] t, input logic [4:0] r, input logic pe);
        @(posedge clk); #1;
        bus.cmd_type     = t;
        bus.cmd_regno    = r;
        bus.cmd_postexec = pe;
        bus.cmd_valid    = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid    = 1'b0;
    endtask

    task automatic wait_px(output logic seen);
        int i = 0;
        while (!bus.postexec_req && i < 20) begin
            @(negedge clk);
            i++;
        end
        seen = bus.postexec_req;
        chk("postexec_req_seen", 32'(seen), 32'd1);
    endtask

    // ROM model: raise postexec_busy after the pulse, hold it, then drop it.
    task automatic rom_exec(input int hold, input logic second, input logic [2:0] exp_err);
        logic seen;
        wait_px(seen);
        if (!seen) return;
        chk("cmd_ready_while_busy", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        bus.postexec_busy = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (second && i == 0) begin
                q_err.push_back(ev_t'{3'd1, cyc + 1});
                bus.cmd_valid = 1'b1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
        bus.postexec_busy = 1'b0;
        q_done.push_back(ev_t'{exp_err, cyc + 1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic seen;
        bus.cmd_valid     = 1'b0;
        bus.cmd_type      = 2'd0;
        bus.cmd_regno     = 5'd0;
        bus.cmd_postexec  = 1'b0;
        bus.dmi_progbuf0  = 32'h0;
        bus.dmi_progbuf1  = 32'h0;
        bus.postexec_busy = 1'b0;
        bus.halted        = 1'b0;
        bus.resume_ack    = 1'b0;
        bus.cmderr_clr    = 1'b0;
        bus.data0_access  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_postexec_req_in_reset", 32'(bus.postexec_req), 32'd0);
        nreset = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cmderr", 32'(bus.cmderr), 32'd0);
        chk("rst_progbuf0", bus.progbuf0, NOP);
        chk("rst_progbuf1", bus.progbuf1, NOP);
        chk("rst_resume_req", 32'(bus.resume_req), 32'd0);

        // Register read x5, no postexec
        bus.halted = 1'b1;
        q_px.push_back(px_t'{32'h14502623, NOP});
        issue(2'd0, 5'd5, 1'b0);
        rom_exec(3, 1'b0, 3'd0);
        repeat (3) @(posedge clk);

        // Register write x10 with postexec
        bus.dmi_progbuf0 = 32'h00A50513;
        q_px.push_back(px_t'{32'h14C02503, 32'h00A50513});
        issue(2'd1, 5'd10, 1'b1);
        rom_exec(3, 1'b0, 3'd0);
        repeat (3) @(posedge clk);

        // Exec while running: halt error, then clear
        bus.halted = 1'b0;
        q_err.push_back(ev_t'{3'd4, -1});
        issue(2'd2, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("halt_err_busy", 32'(bus.busy), 32'd0);
        chk("halt_err_cmderr", 32'(bus.cmderr), 32'd4);
        q_err.push_back(ev_t'{3'd0, cyc + 1});
        bus.cmderr_clr = 1'b1;
        @(posedge clk); #1;
        bus.cmderr_clr = 1'b0;

        // Resume while running is a no-op
        issue(2'd3, 5'd0, 1'b0);
        @(posedge clk); #1;
        chk("resume_noop_busy", 32'(bus.busy), 32'd0);
        chk("resume_noop_req", 32'(bus.resume_req), 32'd0);

        // Busy error from a second command, third command ignored
        bus.halted = 1'b1;
        q_px.push_back(px_t'{32'h14302623, NOP});
        issue(2'd0, 5'd3, 1'b0);
        rom_exec(3, 1'b1, 3'd1);
        repeat (2) @(posedge clk);
        issue(2'd2, 5'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("ignored_busy", 32'(bus.busy), 32'd0);
        chk("ignored_cmderr", 32'(bus.cmderr), 32'd1);
        chk("ignored_progbuf0", bus.progbuf0, 32'h14302623);
        q_err.push_back(ev_t'{3'd0, cyc + 1});
        bus.cmderr_clr = 1'b1;
        @(posedge clk); #1;
        bus.cmderr_clr = 1'b0;

        // Exec progbuf with postexec_busy stuck low -> timeout
        bus.dmi_progbuf0 = 32'h00100093;
        bus.dmi_progbuf1 = 32'h00200113;
        q_px.push_back(px_t'{32'h00100093, 32'h00200113});
        issue(2'd2, 5'd0, 1'b0);
        wait_px(seen);
        if (seen) begin
            q_err.push_back(ev_t'{3'd4, cyc + 17});
            q_done.push_back(ev_t'{3'd4, cyc + 17});
        end
        repeat (20) @(posedge clk);
        #1;
        chk("timeout_progbuf0_kept", bus.progbuf0, 32'h00100093);
        chk("timeout_progbuf1_kept", bus.progbuf1, 32'h00200113);
        chk("timeout_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        q_err.push_back(ev_t'{3'd0, cyc + 1});
        bus.cmderr_clr = 1'b1;
        @(posedge clk); #1;
        bus.cmderr_clr = 1'b0;

        // Resume: ack after 4 cycles, halted falls 2 cycles later
        q_res.push_back(4);
        issue(2'd3, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.resume_ack = 1'b1;
        @(posedge clk); #1;
        bus.resume_ack = 1'b0;
        @(posedge clk); #1;
        bus.halted = 1'b0;
        q_done.push_back(ev_t'{3'd0, cyc + 1});
        @(posedge clk); #1;
        bus.halted = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("resume_done_cmderr", 32'(bus.cmderr), 32'd0);

        // Reset asserted during RES_REQ
        issue(2'd3, 5'd0, 1'b0);
        @(posedge clk); #1;
        chk("res_req_before_reset", 32'(bus.resume_req), 32'd1);
        #1;
        nreset = 1'b0;
        #1;
        chk("reset_resume_req", 32'(bus.resume_req), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_progbuf0", bus.progbuf0, NOP);
        @(negedge clk);
        @(posedge clk); #1;
        nreset     = 1'b1;
        bus.halted = 1'b0;

        repeat (5) @(negedge clk);
        chk("q_px_empty", q_px.size(), 32'd0);
        chk("q_err_empty", q_err.size(), 32'd0);
        chk("q_done_empty", q_done.size(), 32'd0);
        chk("q_res_empty", q_res.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
